muldiv_32: RTL and testbench
============================

Name: muldiv_32

Overview:
- Iterative multiply/divide unit with HI/LO registers.
- Sits directly downstream of the register file and consumes its registered outA/outB read ports as operand_a/operand_b.
- Executes MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes.
- The control unit stalls on busy and reads results from hi/lo via MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration-counter width (must hold WIDTH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  operation: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV
- operand_a  in  WIDTH  multiplicand / dividend (from rf outA)
- operand_b  in  WIDTH  multiplier / divisor (from rf outB)
- hilo_write  in  1  MTHI/MTLO write strobe
- hilo_sel  in  1  0=write LO, 1=write HI
- hilo_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo hold the new result
- div_by_zero  out  1  pulses with done when a DIV/DIVU had operand_b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset wins over every other input in the same cycle and aborts any in-flight operation; hi/lo are cleared, not written with partial results.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 (edge 0):
  - latch op, |operand_a|, |operand_b|, sign flags;
  - magnitudes only for MULT/DIV; unsigned ops use raw values;
  - counter=0, state=RUN, busy=1.
- RUN (edges 1..WIDTH): one iteration per cycle.
  - Multiply: shift-add, one bit of the multiplier per cycle into a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle; remainder WIDTH+1 bits.
  - After iteration WIDTH: state=FIX.
- FIX (edge WIDTH+1):
  - Multiply: product negated if sign_a^sign_b (MULT only); hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, negated if sign_a^sign_b; hi=remainder, negated if sign_a (remainder takes dividend sign); DIV only.
  - done=1 and busy=0 for the following cycle; state=IDLE.
- Latency: start sampled at edge 0 -> done high and hi/lo valid after edge 33 (WIDTH=32). Latency is fixed; there is no early-out.
- Divide by zero: runs the full latency; lo=all-ones, hi=operand_a (raw, unsigned/signed alike); div_by_zero=1 together with done.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored; latched operands are unaffected.
- start in the done cycle: accepted, because state is IDLE; back-to-back operations are legal.
- hilo_write:
  - honoured only in IDLE with start=0; writes the selected register at the edge;
  - dropped while busy;
  - dropped if start=1 in the same cycle (start wins).
- done and div_by_zero: high for exactly one cycle. hi/lo hold their values until the next FIX, hilo_write or reset.
- Operands must be stable only in the start cycle. The rf read issued one cycle earlier satisfies this.

Decomposition:
- Package muldiv_pkg:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state encodings: S_IDLE, S_RUN, S_FIX;
  - WIDTH default; DIV0_QUOT constant (all-ones).
- One natural sub-module: muldiv_signfix. Combinational conditional two's-complement negate of a WIDTH or 2*WIDTH value, instanced for operand absolute values and result correction.
- The FSM, counter and datapath stay in muldiv_32.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy 1..33, done at cycle 33, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; MULT -1*-1 -> hi=0 lo=1.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> done at cycle 33, div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234.
- Start MULTU 5*6, reassert start with new operands at cycle 10, pulse hilo_write at cycle 12, then start DIVU 9/4 in the done cycle:
  - first result hi=0 lo=30, unaffected by the cycle-10 start and cycle-12 write;
  - second result lo=2 hi=1, exactly 33 cycles after its start.
- Reset at cycle 15 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse.
- Following that, hilo_write sel=1 data=0xABCD in IDLE -> hi=0xABCD next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide unit.
//   op_e     - operation select driven on muldiv_32.op
//   state_e  - sequencer states of muldiv_32
//   DEFAULT_WIDTH / DIV0_QUOT - default datapath width and the quotient
//   reported for a division by zero at that width
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Quotient produced by a division by zero (all ones at the default width).
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negate.
//   value_i  [W-1:0]  input value
//   negate_i          1 = output the two's complement of value_i
//   result_o [W-1:0]  value_i or -value_i
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o
);

  assign result_o = negate_i ? -value_i : value_i;

endmodule

// File: rtl/muldiv_32.sv
// muldiv_32: iterative multiply/divide unit with HI/LO result registers.
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start, op               launch MULTU/MULT/DIVU/DIV (sampled only in IDLE)
//   operand_a, operand_b    multiplicand/dividend, multiplier/divisor
//   hilo_write, hilo_sel,   MTHI/MTLO write port (IDLE only, start has priority)
//   hilo_data
//   busy                    operation in flight
//   done, div_by_zero       one-cycle result pulses
//   hi, lo                  HI/LO registers
// One result bit is produced per cycle: start -> WIDTH iterations -> sign fix.
module muldiv_32
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_write,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;   // result (product / quotient) needs negation
  logic               neg_rem_q;   // remainder takes the dividend's sign
  logic               div0_q;
  logic [WIDTH-1:0]   addend_q;    // |multiplicand| for multiply, |divisor| for divide
  logic [WIDTH-1:0]   raw_a_q;     // unmodified dividend, reported on divide by zero
  logic [2*WIDTH-1:0] acc_q;       // product accumulator / quotient shift register
  logic [WIDTH:0]     rem_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand magnitudes; only the signed ops look at the sign bits.
  logic             op_signed;
  logic             op_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign op_signed = op[0];
  assign op_div    = op[1];
  assign sign_a    = op_signed & operand_a[WIDTH-1];
  assign sign_b    = op_signed & operand_b[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .value_i  (operand_a),
    .negate_i (sign_a),
    .result_o (abs_a)
  );

  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .value_i  (operand_b),
    .negate_i (sign_b),
    .result_o (abs_b)
  );

  // Shift-add multiply step: the multiplier sits in acc_q's low half and is
  // consumed LSB first while the partial product grows into the high half.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the trial difference when it does not go negative. The trial is one
  // bit wider than the shifted remainder so its sign bit is always valid.
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ge;
  logic [WIDTH:0]     rem_d;
  logic [2*WIDTH-1:0] div_acc_d;

  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {2'b00, addend_q};
  assign div_ge    = ~div_trial[WIDTH+1];
  assign rem_d     = div_ge ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
  assign div_acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};

  // Result sign correction.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .value_i  (acc_q),
    .negate_i (neg_res_q),
    .result_o (prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quot (
    .value_i  (acc_q[WIDTH-1:0]),
    .negate_i (neg_res_q),
    .result_o (quot_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .value_i  (rem_q[WIDTH-1:0]),
    .negate_i (neg_rem_q),
    .result_o (rem_fix)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      addend_q  <= '0;
      raw_a_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q  <= op_div;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= op_div && (operand_b == '0);
            addend_q  <= op_div ? abs_b : abs_a;
            raw_a_q   <= operand_a;
            acc_q     <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else if (hilo_write) begin
            if (hilo_sel) begin
              hi_q <= hilo_data;
            end else begin
              lo_q <= hilo_data;
            end
          end
        end

        S_RUN: begin
          if (is_div_q) begin
            acc_q <= div_acc_d;
            rem_q <= rem_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            hi_q <= raw_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          done_q  <= 1'b1;
          dbz_q   <= div0_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_32.sv
// Self-checking bench for muldiv_32: directed cases, randomized operations
// against an arithmetic reference model, busy/back-to-back behaviour,
// mid-operation reset and HI/LO writes.
module tb_muldiv_32;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hilo_write;
  logic        hilo_sel;
  logic [31:0] hilo_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_32 dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hilo_write  (hilo_write),
    .hilo_sel    (hilo_sel),
    .hilo_data   (hilo_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operation.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    mdz = 1'b0;
    mhi = '0;
    mlo = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      2'd0: begin
        p   = {32'b0, a} * {32'b0, b};
        mhi = p[63:32];
        mlo = p[31:0];
      end
      2'd1: begin
        p   = sa * sb;
        mhi = p[63:32];
        mlo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          mdz = 1'b1;
          mhi = a;
          mlo = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          mlo = a / b;
          mhi = a % b;
        end else begin
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end
      end
    endcase
  endfunction

  // Drive a start for one edge, then scramble operands to prove they are latched.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    start     = 1'b0;
    op        = 2'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Count edges until done; flag any cycle where busy dropped before done.
  task automatic wait_done(output int cyc, output logic bad);
    cyc = 0;
    bad = 1'b0;
    while (cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (done) break;
      if (!busy) bad = 1'b1;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int   cyc;
    logic bad;
    string id;
    id = $sformatf("op%0d a=%h b=%h", o, a, b);
    launch(o, a, b);
    check({id, " busy_after_start"}, busy, 1);
    wait_done(cyc, bad);
    check({id, " latency"}, cyc, 33);
    check({id, " busy_held"}, bad, 0);
    check({id, " hi"}, hi, ehi);
    check({id, " lo"}, lo, elo);
    check({id, " dbz"}, div_by_zero, edz);
    check({id, " busy_at_done"}, busy, 0);
    @(posedge clock);
    #1;
    check({id, " done_one_cycle"}, {done, div_by_zero}, 0);
    check({id, " hi_hold"}, hi, ehi);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d cycles=%0d", o, a, b, hi, lo, edz, cyc);
  endtask

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rdz, bad, seen_done;
    logic [1:0]  ro;
    int          cyc;

    reset      = 1'b1;
    start      = 1'b0;
    op         = 2'd0;
    operand_a  = '0;
    operand_b  = '0;
    hilo_write = 1'b0;
    hilo_sel   = 1'b0;
    hilo_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    reset = 1'b0;

    // Directed cases with hand-derived results.
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(2'd2, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_op(2'd3, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: ra = 32'h8000_0000;
        4: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      model(ro, ra, rb, rhi, rlo, rdz);
      run_op(ro, ra, rb, rhi, rlo, rdz);
    end

    // start while busy and hilo_write while busy are ignored; start in the
    // done cycle is accepted.
    launch(2'd0, 32'd5, 32'd6);
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == 9) begin
        start = 1'b1; op = 2'd2; operand_a = 32'd77; operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (cyc == 11) begin
        hilo_write = 1'b1; hilo_sel = 1'b0; hilo_data = 32'hDEAD_BEEF;
      end else begin
        hilo_write = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc++;
      if (done) break;
    end
    start      = 1'b0;
    hilo_write = 1'b0;
    check("busy_ignore latency", cyc, 33);
    check("busy_ignore hi", hi, 32'd0);
    check("busy_ignore lo", lo, 32'd30);
    $display("op=0 a=5 b=6 with mid-op start/write -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    launch(2'd2, 32'd9, 32'd4);
    wait_done(cyc, bad);
    check("b2b latency", cyc, 33);
    check("b2b busy_held", bad, 0);
    check("b2b lo", lo, 32'd2);
    check("b2b hi", hi, 32'd1);
    $display("op=2 a=9 b=4 back-to-back -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);

    // Reset in the middle of a divide.
    launch(2'd3, 32'hFFFF_FF9C, 32'd7);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    check("midreset done", done, 0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("midreset no_done", seen_done, 0);
    $display("reset at cycle 15 of DIV -> busy=%0d hi=%h lo=%h", busy, hi, lo);

    // HI/LO writes in IDLE.
    hilo_write = 1'b1; hilo_sel = 1'b1; hilo_data = 32'h0000_ABCD;
    @(posedge clock);
    #1;
    hilo_write = 1'b0;
    check("mthi hi", hi, 32'h0000_ABCD);
    check("mthi lo", lo, 32'h0);
    $display("MTHI 0000abcd -> hi=%h lo=%h", hi, lo);
    hilo_write = 1'b1; hilo_sel = 1'b0; hilo_data = 32'h0000_1357;
    @(posedge clock);
    #1;
    hilo_write = 1'b0;
    check("mtlo lo", lo, 32'h0000_1357);
    check("mtlo hi", hi, 32'h0000_ABCD);
    $display("MTLO 00001357 -> hi=%h lo=%h", hi, lo);

    // start and hilo_write together: start wins, write is dropped.
    hilo_write = 1'b1; hilo_sel = 1'b1; hilo_data = 32'hFFFF_0000;
    launch(2'd0, 32'd2, 32'd3);
    check("start_wins hi", hi, 32'h0000_ABCD);
    check("start_wins busy", busy, 1);
    hilo_sel = 1'b0; hilo_data = 32'h9999_9999;
    @(posedge clock);
    #1;
    hilo_write = 1'b0;
    check("write_while_busy lo", lo, 32'h0000_1357);
    wait_done(cyc, bad);
    check("start_wins latency", cyc + 1, 33);
    check("start_wins result hi", hi, 32'd0);
    check("start_wins result lo", lo, 32'd6);
    $display("op=0 a=2 b=3 with simultaneous write -> hi=%h lo=%h cycles=%0d", hi, lo, cyc + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
